// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg
// Shared types and constants for the gate truth-table sweep controller.
//   state_e  : sweep FSM state (idle, settling on a vector, reporting)
//   TT2_*    : reference truth tables for 2-input gates, bit i = Y at input vector i
//              (vector MSB = A, LSB = B)
package gate_tt_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic [3:0] TT2_XNOR = 4'h9;
    localparam logic [3:0] TT2_XOR  = 4'h6;
    localparam logic [3:0] TT2_AND  = 4'h8;
    localparam logic [3:0] TT2_OR   = 4'hE;
    localparam logic [3:0] TT2_NAND = 4'h7;
    localparam logic [3:0] TT2_NOR  = 4'h1;

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// gate_tt_settle_cnt
// Loadable down-counter timing how long each input vector is held on the gate.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   en         : count down by one; holds at zero
//   load_val   : value loaded on load
//   tc         : terminal count, high while the count is zero
module gate_tt_settle_cnt #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer
// Sweeps every input vector of an N_IN-input, 1-output combinational gate in
// ascending order, holds each for SETTLE cycles, captures Y into a truth table
// and optionally compares it with an expected table.
// Configuration macro: GATE_TT_COMPARE_EN builds the expected latch, comparator
// and lowest-index mismatch encoder; without it pass/mismatch_idx read 0.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a sweep (only honoured while idle)
//   expected     : expected truth table, latched when a sweep starts
//   gate_in      : gate input vector (MSB = A)
//   gate_out     : gate output Y
//   busy         : sweep in progress
//   done         : one-cycle pulse when results are valid
//   truth_table  : bit i = Y captured with gate_in = i
//   pass         : truth_table matches expected
//   mismatch_idx : lowest differing vector index, 0 on pass
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        gate_in,
    input  logic                   gate_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth_table,
    output logic                   pass,
    output logic [N_IN-1:0]        mismatch_idx
);

    localparam int unsigned TT_W  = 1 << N_IN;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // One spare bit so the last-vector compare can never alias after a wrap.
    localparam logic [N_IN:0]      LAST_VEC = (N_IN + 1)'(TT_W - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e            state_q, state_d;
    logic [N_IN:0]     vec_q, vec_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic              done_q, done_d;
    logic              cnt_load, cnt_en, cnt_tc;
    logic              clear_res, upd_res;

    gate_tt_settle_cnt #(
        .WIDTH (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (CNT_LOAD),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        tt_d      = tt_q;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        clear_res = 1'b0;
        upd_res   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSettle;
                    vec_d     = '0;
                    tt_d      = '0;
                    cnt_load  = 1'b1;
                    clear_res = 1'b1;
                end
            end
            StSettle: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    tt_d[vec_q[N_IN-1:0]] = gate_out;
                    if (vec_q == LAST_VEC) begin
                        state_d = StDone;
                    end else begin
                        vec_d    = vec_q + (N_IN + 1)'(1);
                        cnt_load = 1'b1;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                upd_res = 1'b1;
                vec_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            tt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            done_q  <= done_d;
        end
    end

    assign gate_in     = vec_q[N_IN-1:0];
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign truth_table = tt_q;

`ifdef GATE_TT_COMPARE_EN
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] diff;
    logic [N_IN-1:0] idx_c;
    logic            pass_q;
    logic [N_IN-1:0] idx_q;

    assign diff = tt_q ^ exp_q;

    // Scan from the top so the lowest differing index wins.
    always_comb begin
        idx_c = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                idx_c = N_IN'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q  <= '0;
            pass_q <= 1'b0;
            idx_q  <= '0;
        end else if (clear_res) begin
            exp_q  <= expected;
            pass_q <= 1'b0;
            idx_q  <= '0;
        end else if (upd_res) begin
            pass_q <= (diff == '0);
            idx_q  <= idx_c;
        end
    end

    assign pass         = pass_q;
    assign mismatch_idx = idx_q;
`else
    logic unused_cmp;
    assign unused_cmp   = ^{expected, clear_res, upd_res};
    assign pass         = 1'b0;
    assign mismatch_idx = '0;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
module tb_gate_tt_sequencer;
    import gate_tt_pkg::*;

    localparam int N_IN   = 2;
    localparam int SETTLE = 2;
    localparam int TT_W   = 1 << N_IN;
    localparam int SWEEP  = TT_W * SETTLE + 1;  // busy cycles per sweep

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [TT_W-1:0] expected = '0;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] truth_table;
    logic            pass;
    logic [N_IN-1:0] mismatch_idx;

    // Behavioural gate under test: an arbitrary truth table looked up by input.
    logic [TT_W-1:0] gate_tt = '0;
    assign gate_out = gate_tt[gate_in];

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    gate_tt_sequencer #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .expected     (expected),
        .gate_in      (gate_in),
        .gate_out     (gate_out),
        .busy         (busy),
        .done         (done),
        .truth_table  (truth_table),
        .pass         (pass),
        .mismatch_idx (mismatch_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int model_pass(input logic [TT_W-1:0] tt, input logic [TT_W-1:0] ex);
`ifdef GATE_TT_COMPARE_EN
        return (tt == ex) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int model_idx(input logic [TT_W-1:0] tt, input logic [TT_W-1:0] ex);
`ifdef GATE_TT_COMPARE_EN
        for (int i = 0; i < TT_W; i++) begin
            if (tt[i] != ex[i]) return i;
        end
`endif
        return 0;
    endfunction

    // One sweep. restart_at / reset_at: cycle offset after the start edge
    // at which to re-pulse start / pull reset (-1 = never).
    task automatic run_sweep(input logic [TT_W-1:0] tt, input logic [TT_W-1:0] ex,
                             input int restart_at, input int reset_at);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        bit aborted  = 0;
        gate_tt = tt;
        @(negedge clk);
        start    = 1'b1;
        expected = ex;
        @(posedge clk);
        #1;
        start    = 1'b0;
        expected = TT_W'($urandom);  // must not disturb the latched copy
        for (int c = 0; c < SWEEP + 4; c++) begin
            int want_gi;
            if (c > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (c == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", busy, 0);
                check_eq("rst_gate_in", gate_in, 0);
                check_eq("rst_tt", truth_table, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_pass", pass, 0);
                check_eq("rst_idx", mismatch_idx, 0);
                aborted = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c < TT_W * SETTLE) want_gi = c / SETTLE;
            else if (c == TT_W * SETTLE) want_gi = TT_W - 1;
            else want_gi = 0;
            check_eq("gate_in", gate_in, want_gi);
            if (c == 0) begin
                check_eq("clr_pass", pass, 0);
                check_eq("clr_idx", mismatch_idx, 0);
            end
            if (c == SWEEP) begin
                check_eq("truth_table", truth_table, tt);
                check_eq("pass", pass, model_pass(tt, ex));
                check_eq("mismatch_idx", mismatch_idx, model_idx(tt, ex));
                gate_tt = ~tt;  // results must hold while idle
            end
            if (c == SWEEP + 3) begin
                check_eq("hold_tt", truth_table, tt);
                check_eq("hold_pass", pass, model_pass(tt, ex));
                check_eq("hold_idx", mismatch_idx, model_idx(tt, ex));
            end
            if (c == restart_at) start = 1'b1;
        end
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_busy", busy, 0);
        end else begin
            check_eq("busy_cycles", busy_cnt, SWEEP);
            check_eq("done_count", done_cnt, 1);
            check_eq("done_cycle", done_at, SWEEP);
        end
    endtask

    initial begin
        #2;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_gate_in", gate_in, 0);
        check_eq("reset_tt", truth_table, 0);
        check_eq("reset_pass", pass, 0);
        check_eq("reset_idx", mismatch_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_sweep(TT2_XNOR, 4'h9, -1, -1);
        run_sweep(TT2_XNOR, TT2_XOR, -1, -1);
        run_sweep(TT2_XNOR, 4'hD, -1, -1);
        run_sweep(TT2_XNOR, 4'h9, 3, -1);
        run_sweep(TT2_XNOR, 4'h9, SWEEP - 1, -1);  // start on the DONE->IDLE edge
        run_sweep(TT2_XNOR, 4'h9, -1, 5);
        run_sweep(TT2_XNOR, 4'h9, -1, -1);
        run_sweep(TT2_AND, 4'h0, -1, -1);
        run_sweep(TT2_NOR, TT2_OR, -1, -1);

        for (int n = 0; n < 30; n++) begin
            logic [TT_W-1:0] tt;
            logic [TT_W-1:0] ex;
            int rs;
            int rr;
            tt = TT_W'($urandom);
            ex = ($urandom_range(0, 1) == 0) ? tt : TT_W'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? $urandom_range(1, SWEEP - 1) : -1;
            rr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, SWEEP - 1) : -1;
            run_sweep(tt, ex, rs, rr);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
